uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// 8N1 / 8N2 UART transmitter with its own modulo-M baud counter.
// A word is accepted on an edge where start=1 and ready=1, then sent
// LSB first: one start bit, eight data bits, STOP_BITS stop bits, each
// bit held for exactly M clock cycles. tx and ready are registered so
// the serial pin only changes on clk edges at bit boundaries.

module uart_tx_serializer #(
  parameter int M         = 868,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  // Counter wide enough to hold M-1; M >= 2 keeps this at least 1 bit.
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  // Index of the last stop bit (0 for 8N1, 1 for 8N2).
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;
  logic [2:0]      bit_idx_r;
  logic [2:0]      bit_idx_s;
  logic [7:0]      shift_r;
  logic [7:0]      shift_s;
  logic            stop_cnt_r;
  logic            stop_cnt_s;
  logic            tx_r;
  logic            tx_s;
  logic            ready_r;
  logic            ready_s;
  logic            tick_s;

  // Baud tick: last cycle of the current bit period.
  always_comb begin
    tick_s = (cnt_r == CNT_LAST);
  end

  // Next-state, counter and output decode for the frame sequencer.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    bit_idx_s  = bit_idx_r;
    shift_s    = shift_r;
    stop_cnt_s = stop_cnt_r;
    tx_s       = tx_r;
    ready_s    = ready_r;

    case (state_r)
      IDLE: begin
        cnt_s      = CNT_ZERO;
        bit_idx_s  = 3'd0;
        stop_cnt_s = 1'b0;
        if (start) begin
          // Accept: capture the word now so later data changes cannot
          // disturb the frame, and drive the start bit on the next cycle.
          shift_s = data;
          state_s = START;
          tx_s    = 1'b0;
          ready_s = 1'b0;
        end else begin
          state_s = IDLE;
          tx_s    = 1'b1;
          ready_s = 1'b1;
        end
      end

      START: begin
        if (tick_s) begin
          cnt_s     = CNT_ZERO;
          state_s   = DATA;
          bit_idx_s = 3'd0;
          tx_s      = shift_r[0];
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      DATA: begin
        if (tick_s) begin
          cnt_s     = CNT_ZERO;
          shift_s   = {1'b0, shift_r[7:1]};
          bit_idx_s = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
            state_s    = STOP;
            stop_cnt_s = 1'b0;
            tx_s       = 1'b1;
          end else begin
            // Next bit is the one that becomes shift[0] after this shift.
            tx_s = shift_r[1];
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      STOP: begin
        if (tick_s) begin
          cnt_s = CNT_ZERO;
          if (stop_cnt_r == STOP_LAST) begin
            state_s    = IDLE;
            stop_cnt_s = 1'b0;
            ready_s    = 1'b1;
          end else begin
            stop_cnt_s = stop_cnt_r + 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      default: begin
        state_s    = IDLE;
        cnt_s      = CNT_ZERO;
        bit_idx_s  = 3'd0;
        stop_cnt_s = 1'b0;
        tx_s       = 1'b1;
        ready_s    = 1'b1;
      end
    endcase
  end

  // State and output registers; rst aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      stop_cnt_r <= 1'b0;
      tx_r       <= 1'b1;
      ready_r    <= 1'b1;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      bit_idx_r  <= bit_idx_s;
      shift_r    <= shift_s;
      stop_cnt_r <= stop_cnt_s;
      tx_r       <= tx_s;
      ready_r    <= ready_s;
    end
  end

  assign tx    = tx_r;
  assign ready = ready_r;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer: three instances (M=4/8N1, M=5/8N2,
// default M=868/8N1) checked every cycle against a frame-level model,
// plus table-driven frames and hand-written corner-case sequences.

module tb_uart_tx_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v;
  logic [2:0] start_v;
  logic [7:0] data_v [3];
  logic       tx0, tx1, tx2, rd0, rd1, rd2;
  logic [2:0] tx_v;
  logic [2:0] ready_v;

  assign tx_v    = {tx2, tx1, tx0};
  assign ready_v = {rd2, rd1, rd0};

  int mm  [3] = '{4, 5, 868};
  int sbv [3] = '{1, 2, 1};

  uart_tx_serializer #(.M(4), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .data(data_v[0]),
    .tx(tx0), .ready(rd0));
  uart_tx_serializer #(.M(5), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .data(data_v[1]),
    .tx(tx1), .ready(rd1));
  uart_tx_serializer u_dut2 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .data(data_v[2]),
    .tx(tx2), .ready(rd2));

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: a frame is busy for (9+SB)*M cycles after the
  // accepting edge; the line value is picked from the bit slot elapsed/M.
  int         busy    [3] = '{0, 0, 0};
  int         elapsed [3] = '{0, 0, 0};
  logic [7:0] word    [3];
  bit         valid   [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_v[k]) begin
        busy[k]  <= 0;
        valid[k] <= 1'b1;
      end else if (busy[k] != 0) begin
        if (elapsed[k] + 1 == (9 + sbv[k]) * mm[k]) busy[k] <= 0;
        elapsed[k] <= elapsed[k] + 1;
      end else if (start_v[k]) begin
        busy[k]    <= 1;
        elapsed[k] <= 0;
        word[k]    <= data_v[k];
      end
    end
  end

  function automatic logic exp_tx(input int k);
    int slot;
    if (busy[k] == 0) return 1'b1;
    slot = elapsed[k] / mm[k];
    if (slot == 0) return 1'b0;
    if (slot <= 8) return word[k][slot-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (valid[k]) begin
        chk($sformatf("model_tx_i%0d", k), int'(tx_v[k]), int'(exp_tx(k)));
        chk($sformatf("model_ready_i%0d", k), int'(ready_v[k]), int'(busy[k] == 0));
      end
    end
  end

  // Send one word on instance k from an idle negedge, record the line while
  // ready is low, then check frame length, every bit slot and a loopback decode.
  // exp_bits lists the transmitted data bits first-sent-leftmost.
  task automatic run_frame(input int k, input logic [7:0] d, input logic [7:0] exp_bits,
                           input int exp_low, input bit hold);
    int         m;
    int         nslots;
    int         cnt;
    int         idx;
    logic       exp_b;
    bit         ok;
    logic [7:0] rx;
    logic       q [$];
    m      = mm[k];
    nslots = 9 + sbv[k];
    data_v[k]  = d;
    start_v[k] = 1'b1;
    @(negedge clk);
    if (!hold) start_v[k] = 1'b0;
    cnt = 0;
    while (ready_v[k] == 1'b0 && cnt < exp_low + 16) begin
      q.push_back(tx_v[k]);
      cnt++;
      @(negedge clk);
    end
    chk($sformatf("ready_low_len_i%0d", k), cnt, exp_low);
    for (int s = 0; s < nslots; s++) begin
      if (s == 0) exp_b = 1'b0;
      else if (s <= 8) exp_b = exp_bits[8-s];
      else exp_b = 1'b1;
      ok = (q.size() >= (s + 1) * m);
      for (int c = 0; c < m; c++) begin
        if (ok) begin
          if (q[s*m+c] !== exp_b) ok = 1'b0;
        end
      end
      chk($sformatf("bit_slot%0d_i%0d_d%02h", s, k, d), int'(ok), 1);
    end
    rx = 8'h00;
    for (int i = 0; i < 8; i++) begin
      idx = (i + 1) * m + m / 2;
      if (idx < q.size()) rx[i] = q[idx];
    end
    chk($sformatf("loopback_i%0d", k), int'(rx), int'(d));
  endtask

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic [7:0] bits;
    int         low;
  } vec_t;

  vec_t tbl [4];
  int   cnt;

  initial begin
    tbl[0] = '{0, 8'h55, 8'b10101010, 40};
    tbl[1] = '{1, 8'h00, 8'b00000000, 55};
    tbl[2] = '{0, 8'h81, 8'b10000001, 40};
    tbl[3] = '{2, 8'h41, 8'b10000010, 8680};

    rst_v   = 3'b111;
    start_v = 3'b000;
    for (int k = 0; k < 3; k++) data_v[k] = 8'h00;

    // Outputs held idle while reset is asserted
    repeat (3) begin
      @(negedge clk);
      chk("reset_tx", int'(tx_v), 7);
      chk("reset_ready", int'(ready_v), 7);
    end
    rst_v = 3'b000;
    @(negedge clk);

    // Table-driven single frames
    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i].inst, tbl[i].data, tbl[i].bits, tbl[i].low, 1'b0);
    end

    // start held high: back-to-back frames with one idle ready cycle
    run_frame(0, 8'hA3, 8'b11000101, 40, 1'b1);
    chk("gap_idle_tx", int'(tx_v[0]), 1);
    run_frame(0, 8'h0F, 8'b11110000, 40, 1'b0);

    // start and data activity during DATA is ignored
    fork
      run_frame(0, 8'hFF, 8'b11111111, 40, 1'b0);
      begin
        repeat (14) @(negedge clk);
        data_v[0]  = 8'h00;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        data_v[0]  = 8'h3C;
      end
    join
    cnt = 0;
    repeat (12) begin
      if (ready_v[0] == 1'b1 && tx_v[0] == 1'b1) cnt++;
      @(negedge clk);
    end
    chk("no_second_frame", cnt, 12);

    // Reset in the middle of data bit 3
    data_v[0]  = 8'h55;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre_abort_busy", int'(ready_v[0]), 0);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    chk("abort_tx", int'(tx_v[0]), 1);
    chk("abort_ready", int'(ready_v[0]), 1);
    run_frame(0, 8'h81, 8'b10000001, 40, 1'b0);

    // rst and start on the same edge: no frame starts
    rst_v[0]   = 1'b1;
    start_v[0] = 1'b1;
    data_v[0]  = 8'h00;
    @(negedge clk);
    rst_v[0]   = 1'b0;
    start_v[0] = 1'b0;
    cnt = 0;
    repeat (3) begin
      if (ready_v[0] == 1'b1 && tx_v[0] == 1'b1) cnt++;
      @(negedge clk);
    end
    chk("rst_beats_start", cnt, 3);

    // Randomized traffic on the two small instances, checked by the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        rst_v[k]   = ($urandom_range(0, 399) == 0);
        start_v[k] = ($urandom_range(0, 2) == 0);
        data_v[k]  = 8'($urandom);
      end
      @(negedge clk);
    end
    rst_v   = 3'b000;
    start_v = 3'b000;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
